// File: rtl/census_window_3x3.sv
// census_window_3x3: builds a 3x3 window over a raster 8-bit grayscale stream
// using two line buffers and emits one 8-bit census code per interior pixel.
//
// Ports:
//   pclk          - pixel clock, the only clock
//   pclk_reset_n  - synchronous active-low reset
//   pixel_data    - 8-bit grayscale input pixel
//   pixel_valid   - pixel_data valid
//   pixel_ready   - block accepts a pixel this cycle (combinational)
//   census_data   - census code of the window centre
//   census_valid  - census_data and flags valid
//   census_ready  - downstream accepts the census beat
//   census_sof    - first census beat of a frame (centre row 1, col 1)
//   census_eol    - last census beat of an interior line (centre col line_width-2)
//   frame_done    - one-cycle pulse after the last pixel of a frame is accepted
module census_window_3x3 #(
  parameter int unsigned line_width  = 240,
  parameter int unsigned frame_lines = 240
) (
  input  logic       pclk,
  input  logic       pclk_reset_n,
  input  logic [7:0] pixel_data,
  input  logic       pixel_valid,
  output logic       pixel_ready,
  output logic [7:0] census_data,
  output logic       census_valid,
  input  logic       census_ready,
  output logic       census_sof,
  output logic       census_eol,
  output logic       frame_done
);

  localparam int unsigned PIX_W = 8;
  localparam int unsigned COL_W = $clog2(line_width);
  localparam int unsigned ROW_W = $clog2(frame_lines);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Line buffers: lb1 holds the previous row, lb0 the row before that.
  logic [PIX_W-1:0] lb0_q [line_width];
  logic [PIX_W-1:0] lb1_q [line_width];

  // Only the two newest window columns are stored; the third (right) column
  // is the incoming one, so the full 3x3 window exists in win_d on accept.
  // Index [row][col]: row 0 = top, col 0 = left.
  logic [2:0][1:0][PIX_W-1:0] win_q, win_d;
  logic [2:0][2:0][PIX_W-1:0] win_c;

  logic [PIX_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eol_q, eol_d;
  logic             done_q, done_d;

  logic             accept_c;
  logic             last_col_c;
  logic             last_row_c;
  logic             complete_c;
  logic [PIX_W-1:0] code_c;
  logic [PIX_W-1:0] ctr_c;

  // Input may be taken whenever the output register is free or draining.
  assign pixel_ready = !valid_q || census_ready;
  assign accept_c    = pixel_valid && pixel_ready;
  assign last_col_c  = (col_q == COL_W'(line_width - 1));
  assign last_row_c  = (row_q == ROW_W'(frame_lines - 1));
  assign complete_c  = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  // Window as it will be after this accept: stored columns plus new column.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_c[r][0] = win_q[r][0];
      win_c[r][1] = win_q[r][1];
    end
    win_c[0][2] = lb0_q[col_q];
    win_c[1][2] = lb1_q[col_q];
    win_c[2][2] = pixel_data;
  end

  // Census: neighbour strictly less than centre, TL in bit 7 down to BR in bit 0.
  assign ctr_c  = win_c[1][1];
  assign code_c = {win_c[0][0] < ctr_c, win_c[0][1] < ctr_c, win_c[0][2] < ctr_c,
                   win_c[1][0] < ctr_c, win_c[1][2] < ctr_c,
                   win_c[2][0] < ctr_c, win_c[2][1] < ctr_c, win_c[2][2] < ctr_c};

  // Next-state: counters, window shift, output register.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    data_d  = data_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    done_d  = 1'b0;

    if (valid_q && census_ready) begin
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
    end

    if (accept_c) begin
      col_d = last_col_c ? '0 : col_q + COL_W'(1);
      if (last_col_c) begin
        row_d = last_row_c ? '0 : row_q + ROW_W'(1);
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_c[r][1];
        win_d[r][1] = win_c[r][2];
      end
      done_d = last_col_c && last_row_c;
      // Cols 0/1 of each row never complete, so stale columns left over
      // from the previous line are never emitted.
      if (complete_c) begin
        valid_d = 1'b1;
        data_d  = code_c;
        sof_d   = (row_q == ROW_W'(2)) && (col_q == COL_W'(2));
        eol_d   = last_col_c;
      end
    end
  end

  // State registers.
  always_ff @(posedge pclk) begin
    if (!pclk_reset_n) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      done_q  <= done_d;
    end
  end

  // Line buffers need no reset: every entry is rewritten before it is used.
  always_ff @(posedge pclk) begin
    if (pclk_reset_n && accept_c) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= pixel_data;
    end
  end

  assign census_data  = data_q;
  assign census_valid = valid_q;
  assign census_sof   = sof_q;
  assign census_eol   = eol_q;
  assign frame_done   = done_q;

endmodule

// File: doc/census_window_3x3.md
Name: census_window_3x3

Overview:
- Consumes the cropped, decimated 8-bit grayscale pixel stream from the DDR3 grayscale reader on pclk. Frames are raster order with no embedded sync.
- Builds a 3x3 sliding window from two line buffers and emits one 8-bit census code per interior pixel for the downstream block-matching cost stage.
- One instance sits per eye, directly after each reader.

Parameters:
- line_width, 240, pixels per line of incoming stream; must be >= 3
- frame_lines, 240, lines per frame of incoming stream, after decimation; must be >= 3

Ports:
- pclk, input, 1, pixel clock; the only clock
- pclk_reset_n, input, 1, synchronous active-low reset
- pixel_data, input, 8, grayscale pixel from the reader
- pixel_valid, input, 1, pixel_data valid
- pixel_ready, output, 1, block accepts pixel this cycle
- census_data, output, 8, census code of window centre
- census_valid, output, 1, census_data and flags valid
- census_ready, input, 1, downstream accepts census beat
- census_sof, output, 1, first census beat of frame (interior row 1, col 1)
- census_eol, output, 1, last census beat of an interior line (col line_width-2)
- frame_done, output, 1, one-cycle pulse when the last input pixel of a frame is accepted

Behaviour:
- Reset values (pclk_reset_n low at a pclk edge):
  - census_valid, census_sof, census_eol, frame_done, census_data = 0
  - column and row counters = 0
  - window registers = 0
  - line-buffer contents are don't-care; they are overwritten before use.
- Input accept: pixel_ready = !census_valid || census_ready, combinational. A beat is accepted when pixel_valid && pixel_ready.
- Counters:
  - col counts 0..line_width-1; row counts 0..frame_lines-1. Both advance only on accept.
  - col wraps to 0 after line_width-1 and row then increments.
  - row wraps to 0 after frame_lines-1, i.e. a continuous frame stream. frame_done pulses in the cycle after that accept.
- Line buffers:
  - Two buffers, line_width x 8: lb1 holds row-1, lb0 holds row-2.
  - On accept at col c: the old lb1[c] moves into lb0[c], and the new pixel is written to lb1[c].
  - Block RAM with registered read is permitted; the read address is prefetched as the next col, wrapping, so no extra stall is introduced.
- Window: a 3x3 shift register. On accept, columns shift left and the new right column is {lb0[c], lb1[c], pixel}.
- Window emission:
  - A window is complete when the accepted pixel has row >= 2 and col >= 2. Its centre is (row-1, col-1).
  - No output is produced for border pixels. Output count per frame is (line_width-2)*(frame_lines-2).
- Output latency: census_valid rises on the cycle after the accept that completes the window. The output register holds until census_ready. A new accept and an output handshake may occur in the same cycle.
- Census encoding: bit = 1 when neighbour < centre, unsigned, strict. Equal values give 0. Bit order:
  - bit 7: TL
  - bit 6: TC
  - bit 5: TR
  - bit 4: ML
  - bit 3: MR
  - bit 2: BL
  - bit 1: BC
  - bit 0: BR
- Flags:
  - census_sof is asserted with the beat for centre (1,1).
  - census_eol is asserted with the beat for centre col line_width-2.
  - Both are held stable with census_data while the beat is stalled.
- Backpressure: while census_valid && !census_ready, pixel_ready = 0. No input is lost and no output is dropped or duplicated.
- Window across a line wrap: the window shift continues across the wrap. Cols 0 and 1 of the new line never emit, so stale columns from the previous line are never output.
- Reset mid-frame: any in-flight census beat is discarded, and the next accepted pixel is treated as (0,0). Resync with the reader is achieved by resetting both together.
- pixel_valid low: counters and window hold, and the output register behaves as above.

Test Plan:
- Reset checks, with line_width=8 and frame_lines=6 for all tests: assert reset with pixel_valid=1.
  - Required: census_valid=0 and pixel_ready=1 after the reset edge.
  - Required: the first census beat appears only after 2*8+3=19 accepts.
- Constant image, all pixels 0x55, census_ready=1:
  - 24 beats, all census_data=0x00.
  - census_sof on beat 1; census_eol on beats 6,12,18,24.
  - frame_done pulses once after the 48th accept.
- Horizontal ramp, pixel = col*10: every beat is 0x94.
- Vertical ramp, pixel = row*10: every beat is 0xE0.
- Random backpressure: census_ready toggled pseudo-randomly and pixel_valid gapped, over three back-to-back frames of random pixels.
  - Output sequence equals a reference model: 72 beats, no drops or duplicates.
  - census_data and the flags are stable while stalled.
  - pixel_ready=0 exactly when census_valid && !census_ready.
- Reset mid-frame: pulse reset after 30 accepts, then stream a fresh ramp frame.
  - Output equals the clean-frame result, 24 beats of 0x94.
  - No beat from the aborted frame appears.
